// File: rtl/layer_draw_arbiter_if.sv
// Draw-path bundle between the background/object draw blocks and the
// layer compositor.
//   master : draw blocks - drive pixel position, frame strobe, layer
//            requests/colours, background colour and border request.
//   slave  : compositor  - consumes the above, returns the composited RGB,
//            owning layer id, collision pulse, hit mask and frame counter.
interface layer_draw_arbiter_if #(
    parameter int NUM_LAYERS = 4
);
    logic [10:0]             pixelX;
    logic [10:0]             pixelY;
    logic                    startOfFrame;
    logic [NUM_LAYERS-1:0]   layerEnable;
    logic [NUM_LAYERS-1:0]   layerDrawReq;
    logic [8*NUM_LAYERS-1:0] layerRGB;
    logic [7:0]              BG_RGB;
    logic                    bordersDrawReq;
    logic [7:0]              RGBOut;
    logic [2:0]              drawLayerId;
    logic                    collision;
    logic [NUM_LAYERS-1:0]   collisionMask;
    logic [15:0]             frameCount;

    modport master (
        output pixelX, pixelY, startOfFrame, layerEnable, layerDrawReq,
               layerRGB, BG_RGB, bordersDrawReq,
        input  RGBOut, drawLayerId, collision, collisionMask, frameCount
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, layerEnable, layerDrawReq,
               layerRGB, BG_RGB, bordersDrawReq,
        output RGBOut, drawLayerId, collision, collisionMask, frameCount
    );
endinterface

// File: rtl/layer_draw_arbiter.sv
// Per-pixel compositor and collision scheduler for the VGA draw path.
// Picks the highest-priority effective layer (index 0 wins) or the
// background, registers the colour/owner, and reports at most one
// collision pulse per frame plus a per-frame layer-vs-border hit mask.
// Ports:
//   clk   - pixel clock
//   reset - synchronous, active-high
//   bus   - layer_draw_arbiter_if.slave (requests in, composited pixel,
//           collision, collisionMask and frameCount out)
//
// state | meaning
// IDLE  | after reset, waiting for the first frame; events ignored
// ARMED | in a frame, no collision reported yet
// FIRED | collision already reported for this frame
module layer_draw_arbiter #(
    parameter int         NUM_LAYERS      = 4,
    parameter logic [7:0] TRANSPARENT_RGB = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    layer_draw_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

    state_t                state_q, state_d;
    logic [7:0]            rgb_q, rgb_d;
    logic [2:0]            id_q, id_d;
    logic                  collision_q, collision_d;
    logic [NUM_LAYERS-1:0] mask_q, mask_d;
    logic [NUM_LAYERS-1:0] acc_q, acc_d;
    logic [15:0]           frame_q, frame_d;

    logic [NUM_LAYERS-1:0] eff;
    logic [NUM_LAYERS-1:0] hits;
    logic                  multi;
    logic                  evt;
    logic                  sof;

    // Pixel position is informational only.
    logic unused_pixel;
    assign unused_pixel = ^{bus.pixelX, bus.pixelY};

    assign sof = bus.startOfFrame;

    always_comb begin
        eff = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff[i] = bus.layerDrawReq[i] & bus.layerEnable[i]
                   & (bus.layerRGB[8*i +: 8] != TRANSPARENT_RGB);
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(eff & (eff - NUM_LAYERS'(1)));
    assign hits  = eff & {NUM_LAYERS{bus.bordersDrawReq}};
    assign evt   = (bus.bordersDrawReq & (|eff)) | multi;

    // Walk from lowest to highest priority so the lowest index overwrites last.
    always_comb begin
        rgb_d = bus.BG_RGB;
        id_d  = 3'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                rgb_d = bus.layerRGB[8*i +: 8];
                id_d  = 3'(i);
            end
        end
    end

    // A startOfFrame coincident with an event starts the new frame and the
    // event belongs to it; out of IDLE that event is not reported.
    always_comb begin
        state_d     = state_q;
        collision_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof) state_d = ARMED;
            end
            ARMED: begin
                if (evt) begin
                    state_d     = FIRED;
                    collision_d = 1'b1;
                end
            end
            FIRED: begin
                if (sof) begin
                    if (evt) collision_d = 1'b1;
                    else     state_d     = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Coincident hits on startOfFrame go to the new frame's accumulator, not
    // to the mask being published.
    always_comb begin
        acc_d   = acc_q;
        mask_d  = mask_q;
        frame_d = frame_q;
        if (sof) begin
            mask_d  = acc_q;
            acc_d   = hits;
            frame_d = frame_q + 16'd1;
        end else if (state_q == IDLE) begin
            acc_d = '0;
        end else begin
            acc_d = acc_q | hits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rgb_q       <= 8'h00;
            id_q        <= 3'(NUM_LAYERS);
            collision_q <= 1'b0;
            mask_q      <= '0;
            acc_q       <= '0;
            frame_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            id_q        <= id_d;
            collision_q <= collision_d;
            mask_q      <= mask_d;
            acc_q       <= acc_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.RGBOut        = rgb_q;
    assign bus.drawLayerId   = id_q;
    assign bus.collision     = collision_q;
    assign bus.collisionMask = mask_q;
    assign bus.frameCount    = frame_q;
endmodule

// File: doc/layer_draw_arbiter.md
Name: layer_draw_arbiter

Overview:
- Per-pixel compositor and scheduler for the VGA draw path.
- Each cycle it chooses which drawing layer owns the current pixel, from up to NUM_LAYERS sprite/object layers plus the background/border generator, and outputs a registered RGB.
- It also detects layer-vs-border and layer-vs-layer overlaps and reports at most one collision pulse per frame, with a per-frame hit mask.
- It sits between the background/object draw blocks and the VGA output stage.

Parameters:
- NUM_LAYERS, 4: number of object layers; legal range 1..7. Layer 0 has highest priority.
- TRANSPARENT_RGB, 8'hFF: RGB value treated as "no pixel" even when the layer's draw request is high.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- pixelX  in  11  current pixel column; informational, same cycle as requests.
- pixelY  in  11  current pixel row.
- startOfFrame  in  1  one-cycle pulse on the first pixel of a frame.
- layerEnable  in  NUM_LAYERS  static config; 0 masks that layer entirely.
- layerDrawReq  in  NUM_LAYERS  per-layer draw request for the current pixel.
- layerRGB  in  8*NUM_LAYERS  packed RRRGGGBB colours; layer i occupies bits [8i+7:8i].
- BG_RGB  in  8  background colour.
- bordersDrawReq  in  1  background is drawing a border pixel.
- RGBOut  out  8  composited pixel colour.
- drawLayerId  out  3  owner of RGBOut: 0..NUM_LAYERS-1 for a layer, NUM_LAYERS for background.
- collision  out  1  one-cycle collision pulse.
- collisionMask  out  NUM_LAYERS  layers that touched a border during the previous complete frame.
- frameCount  out  16  number of frames since reset.

Behaviour:
- Effective request: eff[i] = layerDrawReq[i] & layerEnable[i] & (layerRGB[i] != TRANSPARENT_RGB).
- Compositing:
  - Fixed priority; the lowest index with eff=1 wins.
  - If no layer is effective, the background wins.
  - Output is registered: RGBOut and drawLayerId reflect the inputs of the previous cycle (latency 1).
  - Layer priority applies even where bordersDrawReq=1, so a layer pixel covers the border.
- Collision event, evaluated on same-cycle inputs:
  - evt = (bordersDrawReq & |eff) | (two or more eff bits set).
- Frame FSM, states IDLE, ARMED, FIRED:
  - IDLE: entered on reset. evt is ignored. startOfFrame moves to ARMED.
  - ARMED: evt moves to FIRED and asserts collision for exactly one cycle, in the cycle after the evt inputs (registered).
  - FIRED: further evt produces no pulse. startOfFrame moves to ARMED.
  - ARMED + startOfFrame: stays ARMED.
  - startOfFrame and evt in the same cycle: the event belongs to the new frame. From ARMED or FIRED the next state is FIRED and a pulse is emitted. From IDLE the next state is ARMED; the event is not counted.
- Hit accumulator (internal, NUM_LAYERS bits):
  - In ARMED or FIRED, OR in (eff & {NUM_LAYERS{bordersDrawReq}}) every cycle.
  - On startOfFrame: collisionMask <= accumulator, including the current cycle's hits only if startOfFrame is not also set in that cycle. The accumulator is then reloaded with the current cycle's hits, because a coincident hit belongs to the new frame.
  - In IDLE, the accumulator is held at 0.
- frameCount: increments on every startOfFrame, including the first one out of IDLE. Wraps 16'hFFFF -> 0.
- Reset values (all synchronous, regardless of the current state):
  - RGBOut = 8'h00.
  - drawLayerId = NUM_LAYERS.
  - collision = 0.
  - collisionMask = 0.
  - frameCount = 0.
  - FSM = IDLE.
  - accumulator = 0.
- Reset while FIRED, mid-frame: no collision pulse until after the next startOfFrame.
- layerEnable may change at any cycle and takes effect on the same cycle's evaluation.

Test Plan:
- Reset held 3 cycles, then released with all inputs low, BG_RGB=8'h1C -> RGBOut=8'h1C and drawLayerId=4 from the second cycle; collision=0; frameCount=0.
- After startOfFrame, layerDrawReq=4'b0110 with RGB1=8'hE0, RGB2=8'h03 -> next cycle RGBOut=8'hE0, drawLayerId=1, collision pulses once. Holding the same inputs for 10 more cycles -> no further pulse.
- Layer 0 request with RGB0=8'hFF (transparent) plus bordersDrawReq=1 -> RGBOut=BG_RGB, drawLayerId=4, no collision, accumulator unchanged.
- Frame N: layer 3 hits the border at one pixel, layer 0 never does; next startOfFrame -> collisionMask=4'b1000, frameCount increments by 1. On the same startOfFrame cycle, layer 0 hits the border -> collisionMask stays 4'b1000; the following frame reports 4'b0001.
- Collision in frame, reset asserted mid-frame, then evt without startOfFrame -> no pulse. Then startOfFrame plus evt in the same cycle -> frameCount=1, state ARMED, no pulse. Next evt -> pulse.
- Preload 16'hFFFF startOfFrame pulses -> frameCount=16'hFFFF; one more pulse -> 16'h0000.
